// File: rtl/spi_ram.sv
// Single-port 8-bit RAM driven by the 10-bit command words of an SPI slave.
// Define SPI_RAM_AUTO_INC_EN to post-increment the write/read addresses (with wrap) after each data access.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  localparam logic [8:0]           DEPTH_W   = 9'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  logic [7:0] mem [MEM_DEPTH];

  logic                 rx_valid_d_q;
  logic                 arm_q;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_vld_q, wr_vld_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 mem_we;
  logic                 fire;
  logic                 addr_oob;

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
  endfunction

  // A word still present when reset releases must drop once before it can fire.
  assign fire     = rx_valid & ~rx_valid_d_q & arm_q & ~rst;
  assign addr_oob = {1'b0, din[7:0]} >= DEPTH_W;

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_vld_d   = wr_vld_q;
    rd_vld_d   = rd_vld_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q & rx_valid;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    if (fire) begin
      tx_valid_d = 1'b0;
      case (din[9:8])
        OP_WR_ADDR: begin
          if (addr_oob) cmd_err_d = 1'b1;
          else begin
            wr_addr_d = din[ADDR_SIZE-1:0];
            wr_vld_d  = 1'b1;
          end
        end
        OP_WR_DATA: begin
          if (!wr_vld_q) cmd_err_d = 1'b1;
          else begin
            mem_we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
            wr_addr_d = next_addr(wr_addr_q);
`endif
          end
        end
        OP_RD_ADDR: begin
          if (addr_oob) cmd_err_d = 1'b1;
          else begin
            rd_addr_d = din[ADDR_SIZE-1:0];
            rd_vld_d  = 1'b1;
          end
        end
        OP_RD_DATA: begin
          if (!rd_vld_q) cmd_err_d = 1'b1;
          else begin
            dout_d     = mem[rd_addr_q];
            tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
            rd_addr_d = next_addr(rd_addr_q);
`endif
          end
        end
        default: cmd_err_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_d_q <= 1'b0;
      arm_q        <= ~rx_valid;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_vld_q     <= 1'b0;
      rd_vld_q     <= 1'b0;
      dout_q       <= '0;
      tx_valid_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      rx_valid_d_q <= rx_valid;
      arm_q        <= arm_q | ~rx_valid;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_vld_q     <= wr_vld_d;
      rd_vld_q     <= rd_vld_d;
      dout_q       <= dout_d;
      tx_valid_q   <= tx_valid_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= din[7:0];
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// Scoreboard bench for spi_ram (MEM_DEPTH=200): stimulus queues expected read/error events,
// a negedge monitor pops and compares them as the DUT raises tx_valid or cmd_err.
module tb_spi_ram;

  localparam int DEPTH = 200;
  localparam int K_RD  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic tx_prev = 1'b0;
  exp_t sb[$];

  spi_ram #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input int kind, input logic [7:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none (cycle %0d)", kind, d, cyc);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (kind == K_RD) chk("read_data", {24'd0, d}, {24'd0, e.data});
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (cmd_err) pop_check(K_ERR, 8'h00);
    if (tx_valid && !tx_prev) pop_check(K_RD, dout);
    tx_prev <= tx_valid;
  end

  task automatic push(input int kind, input logic [7:0] d, input int at);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  // Drive one word for 'hold' cycles, then one low cycle; kind 0 means no response expected.
  task automatic send(input logic [9:0] w, input int hold, input int kind, input logic [7:0] d);
    din = w;
    rx_valid = 1'b1;
    if (kind != 0) push(kind, d, cyc + 1);
    repeat (hold) @(posedge clk);
    #1 rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, idle for 10 cycles
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_dout", {24'd0, dout}, 32'h00);
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
      chk("rst_cmd_err", {31'd0, cmd_err}, 32'h0);
    end
    @(posedge clk);
    #1;

    // Basic write then read-back
    send(10'h012, 1, 0, 8'h00);
    send(10'h1A5, 1, 0, 8'h00);
    send(10'h212, 1, 0, 8'h00);
    send(10'h300, 1, K_RD, 8'hA5);
    chk("tx_fall", {31'd0, tx_valid}, 32'h0);
    chk("dout_hold", {24'd0, dout}, 32'hA5);

    // Word held across reset release is not executed; then read-data without address
    @(posedge clk);
    #1 rst = 1'b1;
    din = 10'h3FF;
    rx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_valid = 1'b0;
    @(posedge clk);
    #1;
    send(10'h3FF, 3, K_ERR, 8'h00);
    chk("rej_tx_valid", {31'd0, tx_valid}, 32'h0);
    chk("rej_dout", {24'd0, dout}, 32'h00);

    // Long rx_valid hold: only the first cycle of the word may act
    send(10'h005, 1, 0, 8'h00);
    din = 10'h1C3;
    rx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 din = 10'h13C;
    repeat (18) @(posedge clk);
    #1 rx_valid = 1'b0;
    @(posedge clk);
    #1;
    send(10'h205, 1, 0, 8'h00);
    send(10'h300, 1, K_RD, 8'hC3);

    // Address range boundary with MEM_DEPTH=200
    do_reset();
    send(10'h0C8, 1, K_ERR, 8'h00);
    send(10'h155, 1, K_ERR, 8'h00);
    send(10'h2C8, 1, K_ERR, 8'h00);
    send(10'h300, 1, K_ERR, 8'h00);
    send(10'h0C7, 1, 0, 8'h00);
    send(10'h177, 1, 0, 8'h00);
    send(10'h2C7, 1, 0, 8'h00);
    din = 10'h300;
    rx_valid = 1'b1;
    push(K_RD, 8'h77, cyc + 1);
    repeat (3) @(posedge clk);
    #1 chk("tx_hold_high", {31'd0, tx_valid}, 32'h1);
    rx_valid = 1'b0;
    @(posedge clk);
    #1 chk("tx_clear_low", {31'd0, tx_valid}, 32'h0);
    chk("dout_keep", {24'd0, dout}, 32'h77);
    @(posedge clk);
    #1;

    // Consecutive data commands at the last address
    do_reset();
    send(10'h0C7, 1, 0, 8'h00);
    send(10'h111, 1, 0, 8'h00);
    send(10'h122, 1, 0, 8'h00);
    send(10'h2C7, 1, 0, 8'h00);
`ifdef SPI_RAM_AUTO_INC_EN
    send(10'h300, 1, K_RD, 8'h11);
    send(10'h300, 1, K_RD, 8'h22);
`else
    send(10'h300, 1, K_RD, 8'h22);
    send(10'h300, 1, K_RD, 8'h22);
`endif

    repeat (5) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missing_event: got none expected kind %0d data %0h at cycle %0d", e.kind, e.data, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
